// File: rtl/in_conditioner.sv
// Input conditioner: two-flop synchronizer, counter-based debouncer, edge pulses
// and a saturating count of accepted rising edges.
module in_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 4,
  parameter int unsigned EVT_W           = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             raw_in,
  output logic             level,
  output logic             rise,
  output logic             fall,
  output logic [EVT_W-1:0] rise_count
);

  typedef enum logic [1:0] {
    STABLE_LOW,
    WAIT_HIGH,
    STABLE_HIGH,
    WAIT_LOW
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [EVT_W-1:0] EVT_ONE  = EVT_W'(1);

  logic             s1_q, s2_q;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, rise_q, fall_q;
  logic [EVT_W-1:0] rise_cnt_q;
  logic             go_high, go_low;

  // Only the second synchronizer stage feeds the debounce decision.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    go_high = 1'b0;
    go_low  = 1'b0;
    case (state_q)
      STABLE_LOW: begin
        cnt_d = '0;
        if (s2_q) begin
          if (DEBOUNCE_CYCLES == 1) go_high = 1'b1;
          else begin
            state_d = WAIT_HIGH;
            cnt_d   = CNT_ONE;
          end
        end
      end
      WAIT_HIGH: begin
        if (!s2_q) begin
          state_d = STABLE_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) go_high = 1'b1;
        else cnt_d = cnt_q + CNT_ONE;
      end
      STABLE_HIGH: begin
        cnt_d = '0;
        if (!s2_q) begin
          if (DEBOUNCE_CYCLES == 1) go_low = 1'b1;
          else begin
            state_d = WAIT_LOW;
            cnt_d   = CNT_ONE;
          end
        end
      end
      WAIT_LOW: begin
        if (s2_q) begin
          state_d = STABLE_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) go_low = 1'b1;
        else cnt_d = cnt_q + CNT_ONE;
      end
      default: begin
        state_d = STABLE_LOW;
        cnt_d   = '0;
      end
    endcase
    if (go_high) begin
      state_d = STABLE_HIGH;
      cnt_d   = '0;
    end
    if (go_low) begin
      state_d = STABLE_LOW;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      state_q    <= STABLE_LOW;
      cnt_q      <= '0;
      level_q    <= 1'b0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      rise_cnt_q <= '0;
    end else begin
      s1_q    <= raw_in;
      s2_q    <= s1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rise_q  <= go_high;
      fall_q  <= go_low;
      if (go_high) level_q <= 1'b1;
      if (go_low)  level_q <= 1'b0;
      if (go_high && (rise_cnt_q != '1)) rise_cnt_q <= rise_cnt_q + EVT_ONE;
    end
  end

  assign level      = level_q;
  assign rise       = rise_q;
  assign fall       = fall_q;
  assign rise_count = rise_cnt_q;

endmodule
